// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared FSM encoding, parameter defaults/limits and width helper
// Contents:
//   hazard_state_e   stall FSM state encoding
//   *_DEF/_MIN/_MAX  parameter defaults and legal ranges
//   cnt_width()      counter width able to hold max_val without wrapping
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MDU_STALL  = 2'd2
  } hazard_state_e;

  localparam int REG_W_DEF               = 5;
  localparam int LOAD_STALL_CYCLES_DEF   = 1;
  localparam int LOAD_STALL_CYCLES_MIN   = 1;
  localparam int LOAD_STALL_CYCLES_MAX   = 4;
  localparam int MDU_LATENCY_DEF         = 4;
  localparam int MDU_LATENCY_MIN         = 1;
  localparam int MDU_LATENCY_MAX         = 32;
  localparam int BRANCH_FLUSH_CYCLES_DEF = 1;
  localparam int BRANCH_FLUSH_CYCLES_MIN = 1;
  localparam int BRANCH_FLUSH_CYCLES_MAX = 2;
  localparam int PERF_W_DEF              = 16;

  // A counter whose maximum is 0 still needs one bit to exist.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_down_counter.sv
// rtl/hazard_down_counter.sv - loadable down counter that stops at zero
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   load_i/load_val_i load count (wins over decrement)
//   dec_i             decrement by one, never below zero
//   count_o, zero_o   current count and count==0 flag
module hazard_down_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use/MDU stall FSM, jump/branch flush and stall counter
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   mem_read_IDEX_i/reg_rt_IDEX_i   load in ID/EX and its destination
//   reg_rs/rt_IFID_i, uses_rs/rt_IFID_i  IF/ID sources and whether they are read
//   is_jump_i, is_jr_i, branch_taken_i   control-transfer requests
//   mdu_start_i, mdu_read_IFID_i         mult/div issue and HI/LO read in IF/ID
//   PC_write_o, IFID_write_o   1 = write; 0 while stalled
//   ctl_flush_o                0 = bubble into ID/EX control
//   IFID_flush_o, IDEX_flush_o 0 = flush that pipeline register
//   mdu_busy_o                 MDU result pending
//   stall_cycles_o             saturating stalled-cycle count
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_W               = REG_W_DEF,
  parameter int LOAD_STALL_CYCLES   = LOAD_STALL_CYCLES_DEF,
  parameter int MDU_LATENCY         = MDU_LATENCY_DEF,
  parameter int BRANCH_FLUSH_CYCLES = BRANCH_FLUSH_CYCLES_DEF,
  parameter int PERF_W              = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_IDEX_i,
  input  logic [REG_W-1:0]  reg_rt_IDEX_i,
  input  logic [REG_W-1:0]  reg_rs_IFID_i,
  input  logic [REG_W-1:0]  reg_rt_IFID_i,
  input  logic              uses_rs_IFID_i,
  input  logic              uses_rt_IFID_i,
  input  logic              is_jump_i,
  input  logic              is_jr_i,
  input  logic              branch_taken_i,
  input  logic              mdu_start_i,
  input  logic              mdu_read_IFID_i,
  output logic              PC_write_o,
  output logic              IFID_write_o,
  output logic              ctl_flush_o,
  output logic              IFID_flush_o,
  output logic              IDEX_flush_o,
  output logic              mdu_busy_o,
  output logic [PERF_W-1:0] stall_cycles_o
);

  localparam int LS_W  = cnt_width(LOAD_STALL_CYCLES - 1);
  localparam int MDU_W = cnt_width(MDU_LATENCY);
  localparam int FL_W  = cnt_width(BRANCH_FLUSH_CYCLES - 1);

  hazard_state_e state_q;
  hazard_state_e state_d;
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;

  logic             load_hazard;
  logic             mdu_hazard;
  logic             stall_raw;
  logic             stall;
  logic             ls_load;
  logic             ls_dec;
  logic [LS_W-1:0]  ls_count;
  logic             ls_zero;
  logic [MDU_W-1:0] mdu_count;
  logic             mdu_zero;
  logic             mdu_busy;
  logic             fl_load;
  logic             fl_dec;
  logic [FL_W-1:0]  fl_count;
  logic             fl_zero;
  logic             jump_flush;
  logic             branch_flush;
  logic             unused_cnt_bits;

  assign load_hazard = mem_read_IDEX_i && (reg_rt_IDEX_i != '0) &&
                       ((uses_rs_IFID_i && (reg_rs_IFID_i == reg_rt_IDEX_i)) ||
                        (uses_rt_IFID_i && (reg_rt_IFID_i == reg_rt_IDEX_i)));
  assign mdu_busy    = !mdu_zero;
  assign mdu_hazard  = mdu_busy && mdu_read_IFID_i;

  // Stall FSM next state. The hazard cycle itself stalls combinationally in
  // IDLE; the LOAD_STALL state only covers the extra cycles beyond the first.
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    ls_load   = 1'b0;
    ls_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_hazard) begin
          stall_raw = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            ls_load = 1'b1;
            state_d = ST_LOAD_STALL;
          end
        end else if (mdu_hazard) begin
          stall_raw = 1'b1;
          state_d   = ST_MDU_STALL;
        end
      end
      ST_LOAD_STALL: begin
        stall_raw = 1'b1;
        ls_dec    = 1'b1;
        // Leave on the edge where the counter reaches zero.
        if (ls_zero || (ls_count == LS_W'(1))) begin
          state_d = ST_IDLE;
        end
      end
      ST_MDU_STALL: begin
        // Release in the first cycle the MDU is no longer busy.
        if (mdu_busy) begin
          stall_raw = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset forces every control output to its idle value even while hazard
  // inputs are present.
  assign stall = stall_raw && reset;

  // Flushes are suppressed while stalled; a held jr/branch is re-presented
  // from the frozen IF/ID register once the stall releases.
  assign fl_load      = branch_taken_i && !stall && (BRANCH_FLUSH_CYCLES > 1);
  assign fl_dec       = !stall;
  assign jump_flush   = reset && !stall && (is_jump_i || is_jr_i);
  assign branch_flush = reset && !stall && (branch_taken_i || !fl_zero);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {PERF_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  hazard_down_counter #(.W(LS_W)) u_load_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ls_load),
    .load_val_i (LS_W'(LOAD_STALL_CYCLES - 1)),
    .dec_i      (ls_dec),
    .count_o    (ls_count),
    .zero_o     (ls_zero)
  );

  // A new start while busy reloads the full latency.
  hazard_down_counter #(.W(MDU_W)) u_mdu_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (mdu_start_i),
    .load_val_i (MDU_W'(MDU_LATENCY)),
    .dec_i      (1'b1),
    .count_o    (mdu_count),
    .zero_o     (mdu_zero)
  );

  // Holds the branch-flush cycles still owed after the first one.
  hazard_down_counter #(.W(FL_W)) u_flush_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (fl_load),
    .load_val_i (FL_W'(BRANCH_FLUSH_CYCLES - 1)),
    .dec_i      (fl_dec),
    .count_o    (fl_count),
    .zero_o     (fl_zero)
  );

  assign unused_cnt_bits = ^{mdu_count, fl_count};

  assign PC_write_o     = !stall;
  assign IFID_write_o   = !stall;
  assign ctl_flush_o    = !stall;
  assign IFID_flush_o   = !(jump_flush || branch_flush);
  assign IDEX_flush_o   = !jump_flush;
  assign mdu_busy_o     = mdu_busy;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_IDEX;
  logic [4:0]  reg_rt_IDEX;
  logic [4:0]  reg_rs_IFID;
  logic [4:0]  reg_rt_IFID;
  logic        uses_rs_IFID;
  logic        uses_rt_IFID;
  logic        is_jump;
  logic        is_jr;
  logic        branch_taken;
  logic        mdu_start;
  logic        mdu_read_IFID;
  logic        PC_write;
  logic        IFID_write;
  logic        ctl_flush;
  logic        IFID_flush;
  logic        IDEX_flush;
  logic        mdu_busy;
  logic [15:0] stall_cycles;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .REG_W               (5),
    .LOAD_STALL_CYCLES   (3),
    .MDU_LATENCY         (4),
    .BRANCH_FLUSH_CYCLES (2),
    .PERF_W              (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read_IDEX_i (mem_read_IDEX),
    .reg_rt_IDEX_i   (reg_rt_IDEX),
    .reg_rs_IFID_i   (reg_rs_IFID),
    .reg_rt_IFID_i   (reg_rt_IFID),
    .uses_rs_IFID_i  (uses_rs_IFID),
    .uses_rt_IFID_i  (uses_rt_IFID),
    .is_jump_i       (is_jump),
    .is_jr_i         (is_jr),
    .branch_taken_i  (branch_taken),
    .mdu_start_i     (mdu_start),
    .mdu_read_IFID_i (mdu_read_IFID),
    .PC_write_o      (PC_write),
    .IFID_write_o    (IFID_write),
    .ctl_flush_o     (ctl_flush),
    .IFID_flush_o    (IFID_flush),
    .IDEX_flush_o    (IDEX_flush),
    .mdu_busy_o      (mdu_busy),
    .stall_cycles_o  (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write enables and control bubble all equal "wr"; flush outputs as given.
  task automatic check_ctrl(input string tag, input logic wr, input logic ifid_fl, input logic idex_fl);
    check({tag, ".pc_write"},   32'(PC_write),   32'(wr));
    check({tag, ".ifid_write"}, 32'(IFID_write), 32'(wr));
    check({tag, ".ctl_flush"},  32'(ctl_flush),  32'(wr));
    check({tag, ".ifid_flush"}, 32'(IFID_flush), 32'(ifid_fl));
    check({tag, ".idex_flush"}, 32'(IDEX_flush), 32'(idex_fl));
  endtask

  task automatic clear_inputs();
    mem_read_IDEX = 1'b0;
    reg_rt_IDEX   = 5'd0;
    reg_rs_IFID   = 5'd0;
    reg_rt_IFID   = 5'd0;
    uses_rs_IFID  = 1'b0;
    uses_rt_IFID  = 1'b0;
    is_jump       = 1'b0;
    is_jr         = 1'b0;
    branch_taken  = 1'b0;
    mdu_start     = 1'b0;
    mdu_read_IFID = 1'b0;
  endtask

  task automatic load_use_rs8();
    mem_read_IDEX = 1'b1;
    reg_rt_IDEX   = 5'd8;
    reg_rs_IFID   = 5'd8;
    uses_rs_IFID  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    load_use_rs8();
    #2;
    check_ctrl("rst_hold", 1'b1, 1'b1, 1'b1);
    check("rst_busy",   32'(mdu_busy), 32'd0);
    check("rst_stalls", 32'(stall_cycles), 32'd0);
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
    #2;
    check_ctrl("idle", 1'b1, 1'b1, 1'b1);

    // Load-use on rs: three stalled cycles.
    tick();
    load_use_rs8();
    #2;
    check_ctrl("lu_c0", 1'b0, 1'b1, 1'b1);
    tick();
    clear_inputs();
    #2;
    check_ctrl("lu_c1", 1'b0, 1'b1, 1'b1);
    tick();
    #2;
    check_ctrl("lu_c2", 1'b0, 1'b1, 1'b1);
    tick();
    #2;
    check_ctrl("lu_c3", 1'b1, 1'b1, 1'b1);
    check("lu_stalls", 32'(stall_cycles), 32'd3);

    // No hazard: rt=0 against rs=0, and rt match with uses_rt=0.
    mem_read_IDEX = 1'b1;
    uses_rs_IFID  = 1'b1;
    #2;
    check("nh_r0", 32'(PC_write), 32'd1);
    tick();
    reg_rt_IDEX  = 5'd8;
    reg_rs_IFID  = 5'd3;
    reg_rt_IFID  = 5'd8;
    #2;
    check("nh_rt_unused", 32'(PC_write), 32'd1);
    tick();
    uses_rt_IFID = 1'b1;
    #2;
    check("lu_rt", 32'(PC_write), 32'd0);
    tick();
    clear_inputs();
    tick();
    tick();
    #2;
    check("lu_rt_rel", 32'(PC_write), 32'd1);
    check("lu_rt_stalls", 32'(stall_cycles), 32'd6);

    // MDU: start, then mfhi next cycle; stalls while busy, releases when idle.
    mdu_start = 1'b1;
    #2;
    check("mdu_c0_busy", 32'(mdu_busy), 32'd0);
    tick();
    mdu_start     = 1'b0;
    mdu_read_IFID = 1'b1;
    #2;
    check("mdu_c1_busy", 32'(mdu_busy), 32'd1);
    check("mdu_c1_pc",   32'(PC_write), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      #2;
      check($sformatf("mdu_c%0d_pc", i), 32'(PC_write), 32'd0);
    end
    tick();
    #2;
    check("mdu_c5_busy", 32'(mdu_busy), 32'd0);
    check_ctrl("mdu_c5", 1'b1, 1'b1, 1'b1);
    check("mdu_stalls", 32'(stall_cycles), 32'd10);
    tick();
    clear_inputs();

    // Taken branch: IF/ID flushed two cycles, ID/EX untouched.
    branch_taken = 1'b1;
    #2;
    check_ctrl("br_c0", 1'b1, 1'b0, 1'b1);
    tick();
    branch_taken = 1'b0;
    #2;
    check_ctrl("br_c1", 1'b1, 1'b0, 1'b1);
    tick();
    #2;
    check_ctrl("br_c2", 1'b1, 1'b1, 1'b1);

    // Plain jump: one-cycle flush of both registers.
    tick();
    is_jump = 1'b1;
    #2;
    check_ctrl("j_c0", 1'b1, 1'b0, 1'b0);
    tick();
    is_jump = 1'b0;
    #2;
    check_ctrl("j_c1", 1'b1, 1'b1, 1'b1);

    // jr held in IF/ID alongside a load-use hazard.
    tick();
    is_jr = 1'b1;
    load_use_rs8();
    #2;
    check_ctrl("jr_c0", 1'b0, 1'b1, 1'b1);
    tick();
    mem_read_IDEX = 1'b0;
    #2;
    check_ctrl("jr_c1", 1'b0, 1'b1, 1'b1);
    tick();
    #2;
    check_ctrl("jr_c2", 1'b0, 1'b1, 1'b1);
    tick();
    #2;
    check_ctrl("jr_c3", 1'b1, 1'b0, 1'b0);
    tick();
    clear_inputs();
    #2;
    check_ctrl("jr_c4", 1'b1, 1'b1, 1'b1);
    check("jr_stalls", 32'(stall_cycles), 32'd13);

    // Asynchronous reset in the middle of a stall with the MDU busy.
    tick();
    load_use_rs8();
    mdu_start = 1'b1;
    tick();
    clear_inputs();
    #2;
    check("ar_pre_pc",   32'(PC_write), 32'd0);
    check("ar_pre_busy", 32'(mdu_busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check_ctrl("ar_mid", 1'b1, 1'b1, 1'b1);
    check("ar_busy",   32'(mdu_busy), 32'd0);
    check("ar_stalls", 32'(stall_cycles), 32'd0);
    tick();
    reset = 1'b1;
    #2;
    check_ctrl("ar_post", 1'b1, 1'b1, 1'b1);
    check("ar_post_busy", 32'(mdu_busy), 32'd0);
    tick();
    load_use_rs8();
    #2;
    check("ar_re_c0", 32'(PC_write), 32'd0);
    tick();
    clear_inputs();
    tick();
    tick();
    #2;
    check("ar_re_c3", 32'(PC_write), 32'd1);
    check("ar_re_stalls", 32'(stall_cycles), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
